// File: rtl/interrupt_sequencer_pkg.sv
// Shared CPU definitions for the interrupt entry/return sequencer:
// sequencer states, fixed return-link value, stack step and PSW field layout.
package interrupt_sequencer_pkg;

  typedef enum logic [3:0] {
    IDLE,
    PUSH_PC,
    PUSH_LR,
    PUSH_PSW,
    PUSH_CEX,
    FETCH_PSW,
    FETCH_PC,
    LOAD,
    POP_CEX,
    POP_PSW,
    POP_LR,
    POP_PC,
    RESTORE
  } state_t;

  // Handler return happens when the CPU jumps to this address.
  localparam logic [15:0] LR_RETURN        = 16'hFFFF;
  // Stack grows downward in 16-bit words.
  localparam logic [15:0] SP_STEP          = 16'd2;
  // New PC sits in the word after the new PSW in the vector table.
  localparam logic [15:0] VECTOR_PC_OFFSET = 16'd2;

  localparam int PSW_IE_BIT  = 4;
  localparam int PSW_PRI_LSB = 5;
  localparam int PSW_PRI_MSB = 7;

  // Replace the priority field of a PSW with the priority being serviced.
  function automatic logic [15:0] psw_with_pri(input logic [15:0] psw,
                                               input logic [2:0]  pri);
    logic [15:0] result;
    result = psw;
    result[PSW_PRI_MSB:PSW_PRI_LSB] = pri;
    return result;
  endfunction

endpackage

// File: rtl/interrupt_sequencer.sv
// Interrupt entry/return sequencer: saves CPU context to the stack, fetches
// the handler PSW/PC from the vector table, and restores context on return.
module interrupt_sequencer
  import interrupt_sequencer_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        int_req,
  input  logic [15:0] int_vector,
  input  logic [2:0]  int_pri,
  input  logic        ret_req,
  input  logic [15:0] pc_in,
  input  logic [15:0] lr_in,
  input  logic [15:0] psw_in,
  input  logic [15:0] sp_in,
  input  logic [7:0]  cex_in,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic [15:0] pc_out,
  output logic [15:0] lr_out,
  output logic [15:0] psw_out,
  output logic [15:0] sp_out,
  output logic [7:0]  cex_out,
  output logic        state_load,
  output logic        int_ack,
  output logic        busy
);

  state_t      state;
  state_t      state_next;

  // Blocks request acceptance on the first edge after reset release.
  logic        armed;

  logic [15:0] saved_vector;
  logic [2:0]  saved_pri;
  logic [15:0] saved_pc;
  logic [15:0] saved_lr;
  logic [15:0] saved_psw;
  logic [7:0]  saved_cex;
  logic [15:0] sp_work;

  logic [15:0] sp_dec;
  logic [15:0] sp_inc;
  logic        accept;
  logic        start_ret;

  assign sp_dec = sp_work - SP_STEP;
  assign sp_inc = sp_work + SP_STEP;

  // An interrupt is taken only when enabled and strictly above current priority;
  // a simultaneous return request loses and is dropped.
  assign accept    = armed && int_req && psw_in[PSW_IE_BIT] &&
                     (int_pri > psw_in[PSW_PRI_MSB:PSW_PRI_LSB]);
  assign start_ret = armed && ret_req && !accept;

  assign busy = (state != IDLE);

  // Arm request acceptance one edge after reset is released.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) armed <= 1'b0;
    else       armed <= 1'b1;
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic and memory handshake / strobe outputs.
  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = 16'h0000;
    mem_wdata  = 16'h0000;
    int_ack    = 1'b0;
    state_load = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          int_ack    = 1'b1;
          state_next = PUSH_PC;
        end else if (start_ret) begin
          state_next = POP_CEX;
        end
      end
      PUSH_PC: begin
        mem_req   = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = sp_dec;
        mem_wdata = saved_pc;
        if (mem_ack) state_next = PUSH_LR;
      end
      PUSH_LR: begin
        mem_req   = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = sp_dec;
        mem_wdata = saved_lr;
        if (mem_ack) state_next = PUSH_PSW;
      end
      PUSH_PSW: begin
        mem_req   = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = sp_dec;
        mem_wdata = saved_psw;
        if (mem_ack) state_next = PUSH_CEX;
      end
      PUSH_CEX: begin
        mem_req   = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = sp_dec;
        mem_wdata = {8'h00, saved_cex};
        if (mem_ack) state_next = FETCH_PSW;
      end
      FETCH_PSW: begin
        mem_req  = 1'b1;
        mem_addr = saved_vector;
        if (mem_ack) state_next = FETCH_PC;
      end
      FETCH_PC: begin
        mem_req  = 1'b1;
        mem_addr = saved_vector + VECTOR_PC_OFFSET;
        if (mem_ack) state_next = LOAD;
      end
      LOAD: begin
        state_load = 1'b1;
        state_next = IDLE;
      end
      POP_CEX: begin
        mem_req  = 1'b1;
        mem_addr = sp_work;
        if (mem_ack) state_next = POP_PSW;
      end
      POP_PSW: begin
        mem_req  = 1'b1;
        mem_addr = sp_work;
        if (mem_ack) state_next = POP_LR;
      end
      POP_LR: begin
        mem_req  = 1'b1;
        mem_addr = sp_work;
        if (mem_ack) state_next = POP_PC;
      end
      POP_PC: begin
        mem_req  = 1'b1;
        mem_addr = sp_work;
        if (mem_ack) state_next = RESTORE;
      end
      RESTORE: begin
        state_load = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Context capture, stack pointer tracking and the values handed back to the CPU;
  // *_out registers are loaded on the final memory ack so they are valid during
  // the state_load cycle and held afterwards.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      saved_vector <= 16'h0000;
      saved_pri    <= 3'd0;
      saved_pc     <= 16'h0000;
      saved_lr     <= 16'h0000;
      saved_psw    <= 16'h0000;
      saved_cex    <= 8'h00;
      sp_work      <= 16'h0000;
      pc_out       <= 16'h0000;
      lr_out       <= LR_RETURN;
      psw_out      <= 16'h0000;
      sp_out       <= 16'h0000;
      cex_out      <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            saved_vector <= int_vector;
            saved_pri    <= int_pri;
            saved_pc     <= pc_in;
            saved_lr     <= lr_in;
            saved_psw    <= psw_in;
            saved_cex    <= cex_in;
            sp_work      <= sp_in;
          end else if (start_ret) begin
            sp_work <= sp_in;
          end
        end
        PUSH_PC, PUSH_LR, PUSH_PSW, PUSH_CEX: begin
          if (mem_ack) sp_work <= sp_dec;
        end
        FETCH_PSW: begin
          if (mem_ack) saved_psw <= mem_rdata;
        end
        FETCH_PC: begin
          if (mem_ack) begin
            pc_out  <= mem_rdata;
            lr_out  <= LR_RETURN;
            psw_out <= psw_with_pri(saved_psw, saved_pri);
            cex_out <= 8'h00;
            sp_out  <= sp_work;
          end
        end
        POP_CEX: begin
          if (mem_ack) begin
            saved_cex <= mem_rdata[7:0];
            sp_work   <= sp_inc;
          end
        end
        POP_PSW: begin
          if (mem_ack) begin
            saved_psw <= mem_rdata;
            sp_work   <= sp_inc;
          end
        end
        POP_LR: begin
          if (mem_ack) begin
            saved_lr <= mem_rdata;
            sp_work  <= sp_inc;
          end
        end
        POP_PC: begin
          if (mem_ack) begin
            pc_out  <= mem_rdata;
            lr_out  <= saved_lr;
            psw_out <= saved_psw;
            cex_out <= saved_cex;
            sp_out  <= sp_inc;
            sp_work <= sp_inc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed testbench for interrupt_sequencer with a behavioural word memory
// that answers requests after a programmable number of wait cycles.
module tb_interrupt_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        int_req = 1'b0;
  logic [15:0] int_vector = 16'h0000;
  logic [2:0]  int_pri = 3'd0;
  logic        ret_req = 1'b0;
  logic [15:0] pc_in = 16'h0000;
  logic [15:0] lr_in = 16'h0000;
  logic [15:0] psw_in = 16'h0000;
  logic [15:0] sp_in = 16'h0000;
  logic [7:0]  cex_in = 8'h00;
  logic        mem_req;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = 16'h0000;
  logic        mem_ack = 1'b0;
  logic [15:0] pc_out;
  logic [15:0] lr_out;
  logic [15:0] psw_out;
  logic [15:0] sp_out;
  logic [7:0]  cex_out;
  logic        state_load;
  logic        int_ack;
  logic        busy;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
  } xact_t;

  xact_t       log_q[$];
  logic [15:0] mem [0:65535];
  int          wait_cycles = 0;
  int          wcnt = 0;
  logic        hold_wr;
  logic [15:0] hold_addr;
  logic [15:0] hold_wdata;

  interrupt_sequencer dut (
    .clock(clock), .reset(reset),
    .int_req(int_req), .int_vector(int_vector), .int_pri(int_pri),
    .ret_req(ret_req),
    .pc_in(pc_in), .lr_in(lr_in), .psw_in(psw_in), .sp_in(sp_in), .cex_in(cex_in),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .pc_out(pc_out), .lr_out(lr_out), .psw_out(psw_out), .sp_out(sp_out),
    .cex_out(cex_out), .state_load(state_load), .int_ack(int_ack), .busy(busy)
  );

  always #5 clock = ~clock;

  // Memory responder: acks after wait_cycles, checks the request is held steady.
  always @(negedge clock) begin
    if (reset) begin
      mem_ack = 1'b0;
      wcnt = 0;
    end else if (mem_req) begin
      if (wcnt == 0) begin
        hold_wr = mem_wr;
        hold_addr = mem_addr;
        hold_wdata = mem_wdata;
      end else begin
        checks++;
        if (mem_wr !== hold_wr || mem_addr !== hold_addr || mem_wdata !== hold_wdata) begin
          failures++;
          $display("FAIL hold_stable: got wr=%b addr=%h wdata=%h want wr=%b addr=%h wdata=%h",
                   mem_wr, mem_addr, mem_wdata, hold_wr, hold_addr, hold_wdata);
        end
      end
      if (wcnt >= wait_cycles) begin
        xact_t x;
        mem_ack = 1'b1;
        wcnt = 0;
        x.wr = mem_wr;
        x.addr = mem_addr;
        if (mem_wr) begin
          mem[mem_addr] = mem_wdata;
          x.data = mem_wdata;
        end else begin
          mem_rdata = mem[mem_addr];
          x.data = mem[mem_addr];
        end
        log_q.push_back(x);
        $display("xact %s addr=%h data=%h", mem_wr ? "WR" : "RD", x.addr, x.data);
      end else begin
        mem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      mem_ack = 1'b0;
      wcnt = 0;
    end
  end

  // Move to a point safely between edges, after the responder has updated.
  task automatic tick();
    @(negedge clock);
    #2;
  endtask

  // Step until state_load is seen or the budget runs out; returns steps taken.
  task automatic wait_load(output int cycles);
    cycles = 0;
    while (!state_load && cycles < 200) begin
      cycles++;
      tick();
    end
  endtask

  task automatic set_ctx(input logic [15:0] vec, input logic [2:0] pri, input logic [15:0] psw,
                         input logic [15:0] sp, input logic [15:0] pc, input logic [15:0] lr,
                         input logic [7:0] cex);
    int_vector = vec; int_pri = pri; psw_in = psw; sp_in = sp;
    pc_in = pc; lr_in = lr; cex_in = cex;
  endtask

  task automatic scramble_ctx();
    set_ctx(16'h5555, 3'd0, 16'h0000, 16'hAAAA, 16'hDEAD, 16'hBEEF, 8'h77);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_ctx(16'hFFC4, 3'd3, 16'h0010, 16'h0800, 16'h1234, 16'h4000, 8'hA5);
    int_req = 1'b1;
    tick(); tick();
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rst_mem_req: got %b want 0", mem_req); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (int_ack !== 1'b0) begin failures++; $display("FAIL rst_int_ack: got %b want 0", int_ack); end
    checks++; if (lr_out !== 16'hFFFF) begin failures++; $display("FAIL rst_lr_out: got %h want ffff", lr_out); end
    checks++; if ({pc_out, psw_out, sp_out, cex_out, state_load, mem_wr, mem_addr, mem_wdata} !== '0) begin
      failures++;
      $display("FAIL rst_outputs_zero: got pc=%h psw=%h sp=%h cex=%h sl=%b wr=%b addr=%h wd=%h want all 0",
               pc_out, psw_out, sp_out, cex_out, state_load, mem_wr, mem_addr, mem_wdata);
    end
    reset = 1'b0;
    #1;
    checks++; if (int_ack !== 1'b0) begin failures++; $display("FAIL first_edge_ack: got %b want 0", int_ack); end
    @(posedge clock); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL first_edge_busy: got %b want 0", busy); end
    int_req = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL post_reset_idle: got %b want 0", busy); end
  endtask

  task automatic test_entry();
    logic        ew [6];
    logic [15:0] ea [6];
    logic [15:0] ed [6];
    int cycles;
    ew = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    ea = '{16'h07FE, 16'h07FC, 16'h07FA, 16'h07F8, 16'hFFC4, 16'hFFC6};
    ed = '{16'h1234, 16'h4000, 16'h0010, 16'h00A5, 16'h00F0, 16'h2000};
    wait_cycles = 0;
    log_q.delete();
    tick();
    set_ctx(16'hFFC4, 3'd3, 16'h0010, 16'h0800, 16'h1234, 16'h4000, 8'hA5);
    int_req = 1'b1;
    #1;
    checks++; if (int_ack !== 1'b1) begin failures++; $display("FAIL entry_ack: got %b want 1", int_ack); end
    tick();
    int_req = 1'b0;
    scramble_ctx();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL entry_busy: got %b want 1", busy); end
    wait_load(cycles);
    checks++; if (cycles !== 6) begin failures++; $display("FAIL entry_latency: got %0d want 6", cycles); end
    checks++; if (state_load !== 1'b1) begin failures++; $display("FAIL entry_state_load: got %b want 1", state_load); end
    checks++; if (pc_out !== 16'h2000) begin failures++; $display("FAIL entry_pc_out: got %h want 2000", pc_out); end
    checks++; if (psw_out !== 16'h0070) begin failures++; $display("FAIL entry_psw_out: got %h want 0070", psw_out); end
    checks++; if (lr_out !== 16'hFFFF) begin failures++; $display("FAIL entry_lr_out: got %h want ffff", lr_out); end
    checks++; if (cex_out !== 8'h00) begin failures++; $display("FAIL entry_cex_out: got %h want 00", cex_out); end
    checks++; if (sp_out !== 16'h07F8) begin failures++; $display("FAIL entry_sp_out: got %h want 07f8", sp_out); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL entry_load_mem_req: got %b want 0", mem_req); end
    tick();
    checks++; if (state_load !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL entry_back_idle: got sl=%b busy=%b want 0 0", state_load, busy);
    end
    checks++; if (log_q.size() !== 6) begin failures++; $display("FAIL entry_xact_count: got %0d want 6", log_q.size()); end
    for (int i = 0; i < 6 && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i].wr !== ew[i] || log_q[i].addr !== ea[i] || log_q[i].data !== ed[i]) begin
        failures++;
        $display("FAIL entry_xact%0d: got wr=%b addr=%h data=%h want wr=%b addr=%h data=%h",
                 i, log_q[i].wr, log_q[i].addr, log_q[i].data, ew[i], ea[i], ed[i]);
      end
    end
  endtask

  task automatic test_return();
    logic [15:0] ea [4];
    logic [15:0] ed [4];
    int cycles;
    ea = '{16'h07F8, 16'h07FA, 16'h07FC, 16'h07FE};
    ed = '{16'h00A5, 16'h0010, 16'h4000, 16'h1234};
    log_q.delete();
    tick();
    sp_in = 16'h07F8;
    ret_req = 1'b1;
    #1;
    checks++; if (int_ack !== 1'b0) begin failures++; $display("FAIL ret_no_ack: got %b want 0", int_ack); end
    tick();
    ret_req = 1'b0;
    sp_in = 16'h0000;
    wait_load(cycles);
    checks++; if (cycles !== 4) begin failures++; $display("FAIL ret_latency: got %0d want 4", cycles); end
    checks++; if (pc_out !== 16'h1234) begin failures++; $display("FAIL ret_pc_out: got %h want 1234", pc_out); end
    checks++; if (lr_out !== 16'h4000) begin failures++; $display("FAIL ret_lr_out: got %h want 4000", lr_out); end
    checks++; if (psw_out !== 16'h0010) begin failures++; $display("FAIL ret_psw_out: got %h want 0010", psw_out); end
    checks++; if (cex_out !== 8'hA5) begin failures++; $display("FAIL ret_cex_out: got %h want a5", cex_out); end
    checks++; if (sp_out !== 16'h0800) begin failures++; $display("FAIL ret_sp_out: got %h want 0800", sp_out); end
    tick();
    checks++; if (log_q.size() !== 4) begin failures++; $display("FAIL ret_xact_count: got %0d want 4", log_q.size()); end
    for (int i = 0; i < 4 && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i].wr !== 1'b0 || log_q[i].addr !== ea[i] || log_q[i].data !== ed[i]) begin
        failures++;
        $display("FAIL ret_xact%0d: got wr=%b addr=%h data=%h want wr=0 addr=%h data=%h",
                 i, log_q[i].wr, log_q[i].addr, log_q[i].data, ea[i], ed[i]);
      end
    end
  endtask

  task automatic test_masking();
    logic [15:0] psws [3];
    logic [2:0]  pris [3];
    psws = '{16'h0000, 16'h00B0, 16'h00B0};
    pris = '{3'd7, 3'd2, 3'd5};
    for (int k = 0; k < 3; k++) begin
      log_q.delete();
      tick();
      set_ctx(16'hFFC4, pris[k], psws[k], 16'h0800, 16'h1234, 16'h4000, 8'hA5);
      int_req = 1'b1;
      #1;
      checks++; if (int_ack !== 1'b0) begin failures++; $display("FAIL mask%0d_ack: got %b want 0", k, int_ack); end
      for (int c = 0; c < 3; c++) begin
        tick();
        checks++;
        if (mem_req !== 1'b0 || busy !== 1'b0) begin
          failures++; $display("FAIL mask%0d_idle: got mem_req=%b busy=%b want 0 0", k, mem_req, busy);
        end
      end
      int_req = 1'b0;
      checks++; if (log_q.size() !== 0) begin failures++; $display("FAIL mask%0d_xacts: got %0d want 0", k, log_q.size()); end
    end
  endtask

  task automatic test_simultaneous();
    int cycles;
    wait_cycles = 0;
    log_q.delete();
    tick();
    set_ctx(16'hFFC4, 3'd1, 16'h0010, 16'h0900, 16'h1111, 16'h2222, 8'h33);
    int_req = 1'b1;
    ret_req = 1'b1;
    #1;
    checks++; if (int_ack !== 1'b1) begin failures++; $display("FAIL simul_ack: got %b want 1", int_ack); end
    tick();
    int_req = 1'b0;
    ret_req = 1'b0;
    wait_load(cycles);
    checks++; if (cycles !== 6) begin failures++; $display("FAIL simul_latency: got %0d want 6", cycles); end
    checks++; if (lr_out !== 16'hFFFF || sp_out !== 16'h08F8 || pc_out !== 16'h2000 || psw_out !== 16'h0030) begin
      failures++;
      $display("FAIL simul_load: got lr=%h sp=%h pc=%h psw=%h want ffff 08f8 2000 0030", lr_out, sp_out, pc_out, psw_out);
    end
    tick();
    checks++;
    if (log_q.size() < 1 || log_q[0].wr !== 1'b1 || log_q[0].addr !== 16'h08FE || log_q[0].data !== 16'h1111) begin
      failures++; $display("FAIL simul_first_xact: got count=%0d want first write 08fe=1111", log_q.size());
    end
  endtask

  task automatic test_wait_wrap();
    logic        ew [6];
    logic [15:0] ea [6];
    logic [15:0] ed [6];
    int cycles;
    ew = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    ea = '{16'h0000, 16'hFFFE, 16'hFFFC, 16'hFFFA, 16'hFFC4, 16'hFFC6};
    ed = '{16'hAAAA, 16'hBBBB, 16'h0010, 16'h00CC, 16'h00F0, 16'h2000};
    wait_cycles = 3;
    log_q.delete();
    tick();
    set_ctx(16'hFFC4, 3'd4, 16'h0010, 16'h0002, 16'hAAAA, 16'hBBBB, 8'hCC);
    int_req = 1'b1;
    tick();
    int_req = 1'b0;
    scramble_ctx();
    wait_load(cycles);
    checks++; if (cycles !== 24) begin failures++; $display("FAIL wait_latency: got %0d want 24", cycles); end
    checks++; if (sp_out !== 16'hFFFA) begin failures++; $display("FAIL wait_sp_out: got %h want fffa", sp_out); end
    checks++; if (psw_out !== 16'h0090) begin failures++; $display("FAIL wait_psw_out: got %h want 0090", psw_out); end
    tick();
    checks++; if (log_q.size() !== 6) begin failures++; $display("FAIL wait_xact_count: got %0d want 6", log_q.size()); end
    for (int i = 0; i < 6 && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i].wr !== ew[i] || log_q[i].addr !== ea[i] || log_q[i].data !== ed[i]) begin
        failures++;
        $display("FAIL wait_xact%0d: got wr=%b addr=%h data=%h want wr=%b addr=%h data=%h",
                 i, log_q[i].wr, log_q[i].addr, log_q[i].data, ew[i], ea[i], ed[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int  cycles;
    bit  found;
    wait_cycles = 3;
    tick();
    set_ctx(16'hFFC4, 3'd3, 16'h0010, 16'h0800, 16'h1234, 16'h4000, 8'hA5);
    int_req = 1'b1;
    tick();
    int_req = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      if (mem_req === 1'b1 && mem_addr === 16'h07FA) found = 1'b1;
      else tick();
    end
    checks++; if (!found) begin failures++; $display("FAIL mid_reach_push_psw: got 0 want 1"); end
    reset = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0 || busy !== 1'b0 || mem_wr !== 1'b0) begin
      failures++; $display("FAIL mid_reset_drop: got mem_req=%b busy=%b wr=%b want 0 0 0", mem_req, busy, mem_wr);
    end
    checks++; if (pc_out !== 16'h0000 || sp_out !== 16'h0000 || lr_out !== 16'hFFFF) begin
      failures++; $display("FAIL mid_reset_outs: got pc=%h sp=%h lr=%h want 0000 0000 ffff", pc_out, sp_out, lr_out);
    end
    tick(); tick();
    reset = 1'b0;
    wait_cycles = 0;
    tick();
    log_q.delete();
    set_ctx(16'hFFC4, 3'd3, 16'h0010, 16'h0800, 16'h1234, 16'h4000, 8'hA5);
    int_req = 1'b1;
    #1;
    checks++; if (int_ack !== 1'b1) begin failures++; $display("FAIL mid_rerun_ack: got %b want 1", int_ack); end
    tick();
    int_req = 1'b0;
    wait_load(cycles);
    checks++; if (cycles !== 6 || sp_out !== 16'h07F8 || pc_out !== 16'h2000) begin
      failures++; $display("FAIL mid_rerun_load: got cycles=%0d sp=%h pc=%h want 6 07f8 2000", cycles, sp_out, pc_out);
    end
    tick();
    checks++; if (log_q.size() !== 6) begin failures++; $display("FAIL mid_rerun_xacts: got %0d want 6", log_q.size()); end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 16'h0000;
    mem[16'hFFC4] = 16'h00F0;
    mem[16'hFFC6] = 16'h2000;
    test_reset();
    test_entry();
    test_return();
    test_masking();
    test_simultaneous();
    test_wait_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/interrupt_sequencer.md
INTERRUPT_SEQUENCER -- requirements
Module: interrupt_sequencer

Interface
REQ-001 SHALL have port clock, input, 1, single system clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port int_req, input, 1, interrupt request from the interrupt controller; held until int_ack.
REQ-004 SHALL have port int_vector, input, 16, vector-table address of the requesting device (e.g. FFC0..FFFC).
REQ-005 SHALL have port int_pri, input, 3, requesting device priority.
REQ-006 SHALL have port ret_req, input, 1, CPU pulse: PC was loaded with FFFF (return from handler).
REQ-007 SHALL have ports pc_in, lr_in, psw_in, sp_in, input, 16 each, plus cex_in, input, 8: live CPU state.
REQ-008 SHALL have ports mem_req, output, 1; mem_wr, output, 1; mem_addr, output, 16; mem_wdata, output, 16; mem_rdata, input, 16; mem_ack, input, 1: word memory handshake.
REQ-009 SHALL have ports pc_out, lr_out, psw_out, sp_out, output, 16 each; cex_out, output, 8; state_load, output, 1: one-cycle strobe; CPU adopts the *_out values.
REQ-010 SHALL have ports int_ack, output, 1, one-cycle acceptance pulse; busy, output, 1, high in every non-IDLE state.

Function
REQ-011 SHALL accept int_req in IDLE only when psw_in[4] (interrupt enable) = 1 and int_pri > psw_in[7:5].
REQ-012 SHALL give int_req priority over ret_req when both are asserted in IDLE in the same cycle; ret_req is then ignored, not queued.
REQ-013 SHALL ignore int_req and ret_req while busy.
REQ-014 SHALL latch int_vector, int_pri, pc_in, lr_in, psw_in, cex_in, sp_in on acceptance and pulse int_ack in the same cycle.
REQ-015 SHALL use states IDLE, PUSH_PC, PUSH_LR, PUSH_PSW, PUSH_CEX, FETCH_PSW, FETCH_PC, LOAD, POP_CEX, POP_PSW, POP_LR, POP_PC, RESTORE.
REQ-016 SHALL, on entry, push PC, LR, PSW, CEX in that order: for each push, SP is decremented by 2 (16-bit wrap, 0000 -> FFFE), then written at the new SP.
REQ-017 SHALL zero-extend cex to 16 bits on push and keep only bits [7:0] on pop.
REQ-018 SHALL then read the new PSW from int_vector and the new PC from int_vector+2 (16-bit wrap).
REQ-019 SHALL, in LOAD, drive pc_out = fetched PC, lr_out = FFFF, cex_out = 00, sp_out = final SP, and psw_out = fetched PSW with bits [7:5] forced to int_pri; state_load pulses one cycle, then IDLE.
REQ-020 SHALL, on ret_req, pop CEX, PSW, LR, PC in that order: for each pop, read at SP, then increment SP by 2 (16-bit wrap).
REQ-021 SHALL, in RESTORE, drive the popped values and the final SP on the *_out ports and pulse state_load one cycle, then IDLE.
REQ-022 SHALL hold mem_req, mem_wr, mem_addr, mem_wdata stable until mem_ack is sampled high; the state advances in the cycle mem_ack is seen; mem_ack while mem_req is low is ignored.
REQ-023 SHALL use no timeout: a missing mem_ack stalls the sequencer in its current state indefinitely.
REQ-024 SHALL drive mem_req low in IDLE, LOAD and RESTORE.
REQ-025 SHALL keep mem_wr = 1 only in the PUSH_* states.
REQ-026 SHALL have entry latency of 4 pushes + 2 reads + 1 LOAD cycle, i.e. 7 states plus any mem_ack wait cycles.
REQ-027 SHALL have exit latency of 4 reads + 1 RESTORE cycle.

Reset
REQ-028 SHALL, on reset asserted at any time (including mid-sequence), enter IDLE immediately and drop any in-flight mem_req without waiting for mem_ack.
REQ-029 SHALL clear all latched registers on reset.
REQ-030 SHALL reset all outputs to 0 except lr_out, which resets to FFFF.
REQ-031 SHALL start no sequence in the first clock edge after reset deasserts.

Structure
REQ-032 SHALL place the state enumeration, the LR_RETURN = FFFF constant, the SP step = 2, and the PSW field positions (enable bit 4, priority bits [7:5]) in the shared CPU package.
REQ-033 SHALL be a single module with no sub-module; the memory handshake is too thin to split out.

Verification
REQ-034 Entry: psw_in=0010, int_pri=3, int_vector=FFC4, sp_in=0800, pc_in=1234, lr_in=4000, cex_in=A5, zero-wait ack -> writes 07FE=1234, 07FC=4000, 07FA=0010, 07F8=00A5; reads FFC4, FFC6; LOAD gives sp_out=07F8, lr_out=FFFF, cex_out=00, psw_out[7:5]=3.
REQ-035 Return: ret_req with sp_in=07F8 and memory as in REQ-034 -> RESTORE gives pc_out=1234, lr_out=4000, psw_out=0010, cex_out=A5, sp_out=0800.
REQ-036 Masking: psw_in[4]=0, or int_pri=2 with psw_in[7:5]=5 -> no int_ack, mem_req stays 0.
REQ-037 Simultaneous int_req and ret_req in IDLE -> the entry sequence runs; ret_req is ignored.
REQ-038 Wait states and wrap: mem_ack delayed 3 cycles on each access with sp_in=0002 -> addresses 0000, FFFE, FFFC, FFFA, and outputs are held stable during each wait.
REQ-039 Reset asserted during PUSH_PSW -> mem_req=0 and busy=0 immediately; a new request after reset completes a full entry.
